// File: rtl/dtcm_icb_ctrl.sv
// rtl/dtcm_icb_ctrl.sv - ICB responder driving the single-port DTCM RAM with an in-order response FIFO
module dtcm_icb_ctrl #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          DATA_WIDTH = 32,
  parameter int          BE_WIDTH   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_addr,
  input  logic                  cmd_read,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [BE_WIDTH-1:0]   cmd_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [31:0] WIN_MASK = (32'd4 << ADDR_WIDTH) - 32'd1;

  logic                  in_win;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      occupancy;
  logic [DATA_WIDTH:0]   push_entry;

  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_read_q, pend_read_d;
  logic                  pend_err_q, pend_err_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];

  always_comb begin
    in_win    = (cmd_addr & ~WIN_MASK) == BASE_ADDR;
    // The pending stage counts as occupied so its push next cycle can never overflow.
    occupancy = count_q + CNT_W'(pend_vld_q);
    cmd_ready = rst_n && (occupancy < CNT_W'(FIFO_DEPTH));
    accept    = cmd_valid && cmd_ready;

    ram_addr       = cmd_addr[ADDR_WIDTH+1:2];
    ram_wr_data    = cmd_wdata;
    ram_wr_en      = accept && !cmd_read && in_win;
    ram_wr_byte_en = ram_wr_en ? cmd_wmask : '0;

    pend_vld_d  = accept;
    pend_read_d = cmd_read;
    pend_err_d  = !in_win;

    push       = pend_vld_q;
    push_entry = {pend_err_q, (pend_read_q && !pend_err_q) ? ram_rd_data : {DATA_WIDTH{1'b0}}};

    rsp_valid = (count_q != '0);
    pop       = rsp_valid && rsp_ready;
    {rsp_err, rsp_rdata} = rsp_valid ? fifo_mem_q[rd_ptr_q] : '0;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q  <= 1'b0;
      pend_read_q <= 1'b0;
      pend_err_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_read_q <= pend_read_d;
      pend_err_q  <= pend_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Entry storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_dtcm_icb_ctrl.sv
// tb/tb_dtcm_icb_ctrl.sv - directed bench for dtcm_icb_ctrl with a behavioural 1-cycle DTCM model
module tb_dtcm_icb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [12:0] ram_addr;
  logic [31:0] ram_wr_data, ram_rd_data;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_byte_en;

  dtcm_icb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_read(cmd_read), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    for (int i = 'h40; i < 'h80; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    ram_rd_data = 32'h0;
  end

  always @(posedge clk) begin
    ram_rd_data <= mem[ram_addr];
    if (ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wr_byte_en[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
    end
  end

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [31:0] rd_q[$];
  logic        er_q[$];
  int          rc_q[$];
  int          ac_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rd_q.push_back(rsp_rdata);
      er_q.push_back(rsp_err);
      rc_q.push_back(cyc);
    end
    if (cmd_valid && cmd_ready) ac_q.push_back(cyc);
    if (ram_wr_en) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    rd_q.delete(); er_q.delete(); rc_q.delete(); ac_q.delete();
  endtask

  task automatic issue(input logic [31:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] m);
    bit done = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_read = rd; cmd_wdata = wd; cmd_wmask = m;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int n);
    for (int i = 0; i < 100 && rd_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    check(tag, rd_q.size(), n);
  endtask

  task automatic stream(input logic [31:0] base, input int n, input int max_cyc,
                        inout int idx, output int stalls);
    stalls = 0;
    for (int c = 0; c < max_cyc && idx < n; c++) begin
      cmd_valid = (idx < n); cmd_read = 1'b1; cmd_addr = base + 32'(idx * 4);
      @(negedge clk);
      if (cmd_valid && !cmd_ready) stalls++;
      if (cmd_valid && cmd_ready) idx++;
      @(posedge clk); #1;
    end
  endtask

  int idx, stalls, wsnap, gaps;

  initial begin
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 32'h9000_0000;
    cmd_wdata = 32'hFFFF_FFFF; cmd_wmask = 4'hF;
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_ram_wr_en", ram_wr_en, 0);
    check("rst_ram_be", ram_wr_byte_en, 0);
    #4;
    rst_n = 1'b1; cmd_valid = 1'b0;
    @(posedge clk); #1;

    // 1: write then read back, latency 2
    clear_q();
    issue(32'h9000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF);
    issue(32'h9000_0010, 1'b1, 32'h0, 4'h0);
    wait_rsp("t1_cnt", 2);
    check("t1_wr_err", er_q[0], 0);
    check("t1_wr_rdata", rd_q[0], 0);
    check("t1_rd_err", er_q[1], 0);
    check("t1_rd_rdata", rd_q[1], 32'hDEAD_BEEF);
    check("t1_latency", rc_q[1] - ac_q[1], 2);
    check("t1_wr_cnt", wr_cnt, 1);

    // 2: partial byte mask
    clear_q();
    issue(32'h9000_0010, 1'b0, 32'h1122_3344, 4'b0101);
    issue(32'h9000_0010, 1'b1, 32'h0, 4'h0);
    wait_rsp("t2_cnt", 2);
    check("t2_rd_rdata", rd_q[1], 32'hDE22_BE44);

    // 3: out-of-window read and write
    clear_q();
    wsnap = wr_cnt;
    issue(32'h8000_0000, 1'b1, 32'h0, 4'h0);
    issue(32'h8000_0010, 1'b0, 32'hFFFF_FFFF, 4'hF);
    wait_rsp("t3_cnt", 2);
    check("t3_rd_err", er_q[0], 1);
    check("t3_rd_rdata", rd_q[0], 0);
    check("t3_wr_err", er_q[1], 1);
    check("t3_no_write", wr_cnt - wsnap, 0);

    // 4: backpressure fills exactly FIFO_DEPTH commands
    clear_q();
    rsp_ready = 1'b0; idx = 0;
    stream(32'h9000_0100, 6, 12, idx, stalls);
    check("t4_accepted", idx, 4);
    check("t4_cmd_ready", cmd_ready, 0);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_head_hold", rsp_rdata, 32'hC0DE_0040);
    check("t4_none_popped", rd_q.size(), 0);
    rsp_ready = 1'b1;
    stream(32'h9000_0100, 6, 30, idx, stalls);
    cmd_valid = 1'b0;
    check("t4_all_accepted", idx, 6);
    wait_rsp("t4_cnt", 6);
    for (int k = 0; k < 6; k++) check($sformatf("t4_rdata%0d", k), rd_q[k], 32'hC0DE_0040 + 32'(k));

    // 5: sustained throughput
    @(posedge clk); #1;
    clear_q();
    idx = 0;
    stream(32'h9000_0140, 16, 40, idx, stalls);
    cmd_valid = 1'b0;
    check("t5_accepted", idx, 16);
    check("t5_stalls", stalls, 0);
    wait_rsp("t5_cnt", 16);
    for (int k = 0; k < 16; k++) check($sformatf("t5_rdata%0d", k), rd_q[k], 32'hC0DE_0050 + 32'(k));
    gaps = 0;
    for (int k = 1; k < 16; k++) if (rc_q[k] - rc_q[k-1] != 1) gaps++;
    check("t5_gaps", gaps, 0);

    // 6: reset with queued responses
    clear_q();
    rsp_ready = 1'b0;
    issue(32'h9000_0020, 1'b0, 32'hCAFE_F00D, 4'hF);
    issue(32'h9000_0100, 1'b1, 32'h0, 4'h0);
    issue(32'h9000_0104, 1'b1, 32'h0, 4'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("t6_queued", rsp_valid, 1);
    #2;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1;
    #1;
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_rsp_rdata", rsp_rdata, 0);
    check("t6_rst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("t6_no_stale", rd_q.size(), 0);
    check("t6_rsp_idle", rsp_valid, 0);
    issue(32'h9000_0020, 1'b1, 32'h0, 4'h0);
    issue(32'h9000_0010, 1'b1, 32'h0, 4'h0);
    wait_rsp("t6_cnt", 2);
    check("t6_persist0", rd_q[0], 32'hCAFE_F00D);
    check("t6_persist1", rd_q[1], 32'hDE22_BE44);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
